// File: rtl/two_bit_1to4demux_router_pkg.sv
// Shared encodings for the 2-bit 1-to-4 demux router: FSM states, lane indices
// and the round-robin pointer step.
package two_bit_1to4demux_router_pkg;

    typedef enum logic [1:0] {
        S_MANUAL = 2'd0,
        S_RR     = 2'd1,
        S_DRAIN  = 2'd2
    } state_t;

    localparam int LANES = 4;

    localparam logic [1:0] LANE_U = 2'd0;
    localparam logic [1:0] LANE_V = 2'd1;
    localparam logic [1:0] LANE_W = 2'd2;
    localparam logic [1:0] LANE_X = 2'd3;

    // Pointer wraps naturally in two bits: 0->1->2->3->0.
    function automatic logic [1:0] rr_step(input logic [1:0] ptr);
        return ptr + 2'd1;
    endfunction

endpackage

// File: rtl/two_bit_1to4demux_router_if.sv
// Symbol-stream and lane bundle for the demux router. The master side is the
// producer/consumer environment; the slave side is the router itself.
interface two_bit_1to4demux_router_if #(
    parameter int WIDTH = 2
);
    logic [WIDTH-1:0] d;
    logic             in_valid;
    logic             in_ready;
    logic [1:0]       s;
    logic             mode_req;
    logic [WIDTH-1:0] u;
    logic [WIDTH-1:0] v;
    logic [WIDTH-1:0] w;
    logic [WIDTH-1:0] x;
    logic [3:0]       out_valid;
    logic [3:0]       out_ready;
    logic             mode;
    logic [7:0]       cnt;

    modport master (
        output d, in_valid, s, mode_req, out_ready,
        input  in_ready, u, v, w, x, out_valid, mode, cnt
    );

    modport slave (
        input  d, in_valid, s, mode_req, out_ready,
        output in_ready, u, v, w, x, out_valid, mode, cnt
    );
endinterface

// File: rtl/two_bit_1to4demux_router_lane_reg.sv
// One-entry holding register for a single output lane. A load in the same edge
// as a drain wins, so the lane stays valid with the new symbol.
module demux_lane_reg #(
    parameter int WIDTH = 2
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             drain,
    input  logic [WIDTH-1:0] din,
    output logic [WIDTH-1:0] data,
    output logic             valid
);
    logic [WIDTH-1:0] data_reg;
    logic             valid_reg;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            data_reg  <= '0;
            valid_reg <= 1'b0;
        end else begin
            if (load) begin
                data_reg <= din;
            end
            valid_reg <= load | (valid_reg & ~drain);
        end
    end

    assign data  = data_reg;
    assign valid = valid_reg;
endmodule

// File: rtl/two_bit_1to4demux_router.sv
// Routes a 2-bit symbol stream to four independently-stalling lanes, chosen by
// the explicit select or a round-robin pointer; mode changes wait for empty lanes.
module two_bit_1to4demux_router
    import two_bit_1to4demux_router_pkg::*;
#(
    parameter int WIDTH = 2
) (
    input logic                       clk,
    input logic                       reset,
    two_bit_1to4demux_router_if.slave bus
);
    state_t     state_reg, state_next;
    logic       mode_reg, mode_next;
    logic [1:0] rr_reg, rr_next;
    logic [7:0] cnt_reg;

    logic [1:0]       target;
    logic             in_ready_int;
    logic             accept;
    logic [3:0]       load;
    logic [3:0]       drain;
    logic [3:0]       lane_valid;
    logic [WIDTH-1:0] lane_data [LANES];

    assign target       = (state_reg == S_RR) ? rr_reg : bus.s;
    assign in_ready_int = (state_reg != S_DRAIN) &
                          (~lane_valid[target] | bus.out_ready[target]);
    assign accept       = bus.in_valid & in_ready_int;

    generate
        for (genvar gi = 0; gi < LANES; gi++) begin : g_lane
            assign load[gi]  = accept & (target == 2'(gi));
            assign drain[gi] = lane_valid[gi] & bus.out_ready[gi];

            demux_lane_reg #(.WIDTH(WIDTH)) u_lane (
                .clk   (clk),
                .reset (reset),
                .load  (load[gi]),
                .drain (drain[gi]),
                .din   (bus.d),
                .data  (lane_data[gi]),
                .valid (lane_valid[gi])
            );
        end
    endgenerate

    always_comb begin
        state_next = state_reg;
        mode_next  = mode_reg;
        rr_next    = rr_reg;

        if ((state_reg == S_RR) && accept) begin
            rr_next = rr_step(rr_reg);
        end

        case (state_reg)
            S_MANUAL: begin
                if (bus.mode_req) begin
                    state_next = (lane_valid == 4'b0000) ? S_RR : S_DRAIN;
                end
            end
            S_RR: begin
                if (!bus.mode_req) begin
                    state_next = (lane_valid == 4'b0000) ? S_MANUAL : S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (lane_valid == 4'b0000) begin
                    state_next = bus.mode_req ? S_RR : S_MANUAL;
                end
            end
            default: state_next = S_MANUAL;
        endcase

        // mode only moves when a settled state is entered; it holds through a drain.
        case (state_next)
            S_MANUAL: mode_next = 1'b0;
            S_RR:     mode_next = 1'b1;
            default:  mode_next = mode_reg;
        endcase

        if ((state_next == S_RR) && (state_reg != S_RR)) begin
            rr_next = LANE_U;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_reg <= S_MANUAL;
            mode_reg  <= 1'b0;
            rr_reg    <= LANE_U;
            cnt_reg   <= 8'd0;
        end else begin
            state_reg <= state_next;
            mode_reg  <= mode_next;
            rr_reg    <= rr_next;
            if (accept) begin
                cnt_reg <= cnt_reg + 8'd1;
            end
        end
    end

    assign bus.in_ready  = in_ready_int;
    assign bus.out_valid = lane_valid;
    assign bus.mode      = mode_reg;
    assign bus.cnt       = cnt_reg;
    assign bus.u         = lane_data[LANE_U];
    assign bus.v         = lane_data[LANE_V];
    assign bus.w         = lane_data[LANE_W];
    assign bus.x         = lane_data[LANE_X];
endmodule

// File: tb/tb_two_bit_1to4demux_router.sv
// Scoreboard bench: accepted symbols are queued per lane; the monitor pops and
// compares whenever a lane handshakes, and checks valid/mode/count every cycle.
module tb_two_bit_1to4demux_router;
    logic clk = 1'b0;
    logic reset = 1'b1;

    two_bit_1to4demux_router_if #(.WIDTH(2)) bus ();

    two_bit_1to4demux_router #(.WIDTH(2)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;

    // Reference model: each lane is a queue of undelivered symbols.
    logic [1:0] lq [4][$];
    logic       cur_mode = 1'b0;
    logic       draining = 1'b0;
    logic [1:0] rr = 2'd0;
    logic [7:0] mcnt = 8'd0;
    logic       pre_empty = 1'b1;
    int         n_acc = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s got=%0d want=%0d t=%0t", name, act, exp, $time);
        end
    endtask

    function automatic logic [1:0] lane_val(input int k);
        case (k)
            0:       return bus.u;
            1:       return bus.v;
            2:       return bus.w;
            default: return bus.x;
        endcase
    endfunction

    // Monitor: compares presented state, then consumes symbols handed off this cycle.
    always @(negedge clk) begin
        if (!reset) begin
            logic [3:0] exp_ov;
            exp_ov = 4'b0000;
            for (int k = 0; k < 4; k++) exp_ov[k] = (lq[k].size() != 0);
            pre_empty = (exp_ov == 4'b0000);
            chk("out_valid", int'(bus.out_valid), int'(exp_ov));
            chk("mode", int'(bus.mode), int'(cur_mode));
            chk("cnt", int'(bus.cnt), int'(mcnt));
            for (int k = 0; k < 4; k++) begin
                if (exp_ov[k] && bus.out_ready[k]) begin
                    logic [1:0] e;
                    e = lq[k].pop_front();
                    chk($sformatf("lane%0d_data", k), int'(lane_val(k)), int'(e));
                end
            end
        end
    end

    // One clock of stimulus; afterwards the model expectation for the coming edge is queued.
    task automatic step(input logic iv, input logic [1:0] dd, input logic [1:0] ss,
                        input logic mr, input logic [3:0] ordy);
        logic [1:0] t;
        logic       exp_rdy;
        @(posedge clk);
        #1;
        bus.in_valid  = iv;
        bus.d         = dd;
        bus.s         = ss;
        bus.mode_req  = mr;
        bus.out_ready = ordy;
        @(negedge clk);
        #1;
        t = cur_mode ? rr : ss;
        exp_rdy = !draining && (lq[t].size() == 0);
        chk("in_ready", int'(bus.in_ready), int'(exp_rdy));
        if (iv && exp_rdy) begin
            lq[t].push_back(dd);
            mcnt++;
            n_acc++;
            if (cur_mode) rr++;
            $display("accept #%0d d=%0d lane=%0d mode=%0d", n_acc, dd, t, cur_mode);
        end
        if (!draining) begin
            if (mr != cur_mode) begin
                if (pre_empty) begin
                    cur_mode = mr;
                    rr = 2'd0;
                end else begin
                    draining = 1'b1;
                end
            end
        end else if (pre_empty) begin
            draining = 1'b0;
            cur_mode = mr;
            rr = 2'd0;
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0] ds [4];
        bus.in_valid = 0; bus.d = 0; bus.s = 0; bus.mode_req = 0; bus.out_ready = 0;
        repeat (3) @(posedge clk);
        @(negedge clk); #2;
        reset = 1'b0;
        chk("rst_u", int'(bus.u), 0);
        chk("rst_v", int'(bus.v), 0);
        chk("rst_w", int'(bus.w), 0);
        chk("rst_x", int'(bus.x), 0);

        // Manual routing, all consumers ready.
        ds[0] = 2'd1; ds[1] = 2'd0; ds[2] = 2'd3; ds[3] = 2'd2;
        for (int i = 0; i < 4; i++) step(1'b1, ds[i], 2'(i), 1'b0, 4'hF);
        repeat (2) step(1'b0, 2'd0, 2'd0, 1'b0, 4'hF);

        // Backpressure on lane u, then simultaneous drain and refill.
        step(1'b1, 2'd1, 2'd0, 1'b0, 4'h0);
        repeat (3) step(1'b1, 2'd3, 2'd0, 1'b0, 4'h0);
        step(1'b1, 2'd3, 2'd0, 1'b0, 4'h1);
        step(1'b0, 2'd0, 2'd0, 1'b0, 4'h0);
        repeat (2) step(1'b0, 2'd0, 2'd0, 1'b0, 4'hF);

        // Round-robin with empty lanes.
        step(1'b0, 2'd0, 2'd0, 1'b1, 4'hF);
        for (int i = 0; i < 8; i++) step(1'b1, 2'(i), 2'(3 - (i % 4)), 1'b1, 4'hF);
        repeat (2) step(1'b0, 2'd0, 2'd0, 1'b1, 4'hF);

        // Mode change while lane w is stalled.
        step(1'b0, 2'd0, 2'd0, 1'b0, 4'hF);
        step(1'b0, 2'd0, 2'd0, 1'b0, 4'hF);
        step(1'b1, 2'd2, 2'd2, 1'b0, 4'b1011);
        repeat (4) step(1'b1, 2'd1, 2'd1, 1'b1, 4'b1011);
        repeat (3) step(1'b1, 2'd3, 2'd2, 1'b1, 4'hF);
        repeat (3) step(1'b0, 2'd0, 2'd0, 1'b1, 4'hF);

        // Reset mid-stream with every lane full, in round-robin mode.
        for (int i = 0; i < 4; i++) step(1'b1, 2'(3 - i), 2'd0, 1'b1, 4'h0);
        step(1'b0, 2'd0, 2'd0, 1'b1, 4'h0);
        @(posedge clk); #2;
        bus.in_valid = 1'b0; bus.mode_req = 1'b0;
        reset = 1'b1;
        #1;
        chk("async_out_valid", int'(bus.out_valid), 0);
        chk("async_cnt", int'(bus.cnt), 0);
        chk("async_mode", int'(bus.mode), 0);
        for (int k = 0; k < 4; k++) lq[k].delete();
        mcnt = 8'd0; cur_mode = 1'b0; draining = 1'b0; rr = 2'd0;
        @(negedge clk); #2;
        reset = 1'b0;

        // Random mixed traffic with occasional mode requests.
        begin
            logic mr;
            mr = 1'b0;
            for (int i = 0; i < 500; i++) begin
                if ($urandom_range(0, 29) == 0) mr = ~mr;
                step(1'($urandom_range(0, 3) != 0), 2'($urandom_range(0, 3)),
                     2'($urandom_range(0, 3)), mr, 4'($urandom_range(0, 15)));
            end
        end
        repeat (4) step(1'b0, 2'd0, 2'd0, 1'b0, 4'hF);

        // Sustained manual traffic, enough to wrap the counter.
        for (int i = 0; i < 300; i++)
            step(1'b1, 2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)), 1'b0, 4'hF);
        repeat (3) step(1'b0, 2'd0, 2'd0, 1'b0, 4'hF);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
